// File: rtl/gpio_event_int.sv
// GPIO change detector: synchronises the pads, snapshots input-pin changes and
// reports each one as a time-tagged frame on the shared slave output bus.
module gpio_event_int #(
  parameter int         WIDTH    = 24,
  parameter logic [7:0] EVT_CHAR = 8'h67
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gpio_in,
  input  logic [WIDTH-1:0] gpio_direction,
  input  logic             evt_enable,
  input  logic [7:0]       global_counter,
  output logic             incr_ctr,
  output logic [7:0]       sl_data,
  output logic             sl_arb_request,
  input  logic             sl_arb_grant,
  output logic             sl_data_latch,
  output logic             evt_overrun
);

  localparam int NBYTES = (WIDTH + 7) / 8;
  localparam int NFRAME = NBYTES + 2;
  localparam int IW     = (NFRAME > 1) ? $clog2(NFRAME) : 1;
  localparam int PW     = NBYTES * 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [WIDTH-1:0] sync1_reg, gpio_s_reg, gpio_prev_reg;
  logic [1:0]       warm_reg;
  logic             pend_reg, pend_next_reg;
  logic [WIDTH-1:0] snap_reg, snap_next_reg;
  logic [7:0]       tag_reg, tag_next_reg;
  logic [1:0]       state_reg;
  logic [IW-1:0]    idx_reg;
  logic             incr_reg, overrun_reg;

  logic [WIDTH-1:0] change;
  logic             any_change;
  logic             sending;
  logic             last_byte;
  logic [PW-1:0]    snap_pad;
  logic [7:0]       frame_bytes [NFRAME];

  // Changes are only trusted once the synchroniser holds a real pad sample
  // and gpio_prev has been loaded from it (warm_reg saturates at 3).
  assign change     = (gpio_s_reg ^ gpio_prev_reg) & ~gpio_direction & {WIDTH{evt_enable}};
  assign any_change = (|change) && (warm_reg == 2'd3);

  assign sending   = (state_reg == ST_SEND) && sl_arb_grant;
  assign last_byte = (idx_reg == IW'(NFRAME - 1));

  assign snap_pad       = PW'(snap_reg);
  assign frame_bytes[0] = EVT_CHAR;
  assign frame_bytes[1] = tag_reg;
  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_level_byte
      assign frame_bytes[2 + gi] = snap_pad[(NBYTES - 1 - gi) * 8 +: 8];
    end
  endgenerate

  assign sl_data_latch  = sending;
  assign sl_data        = sending ? frame_bytes[idx_reg] : 8'h00;
  assign sl_arb_request = (state_reg == ST_REQ) || (state_reg == ST_SEND);
  assign incr_ctr       = incr_reg;
  assign evt_overrun    = overrun_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg     <= '0;
      gpio_s_reg    <= '0;
      gpio_prev_reg <= '0;
      warm_reg      <= 2'd0;
    end else begin
      sync1_reg     <= gpio_in;
      gpio_s_reg    <= sync1_reg;
      gpio_prev_reg <= gpio_s_reg;
      if (warm_reg != 2'd3) warm_reg <= warm_reg + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_reg      <= 1'b0;
      snap_reg      <= '0;
      tag_reg       <= 8'h00;
      pend_next_reg <= 1'b0;
      snap_next_reg <= '0;
      tag_next_reg  <= 8'h00;
      incr_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      incr_reg <= 1'b0;
      if (sending && last_byte) pend_reg <= 1'b0;
      if (state_reg == ST_DONE && pend_next_reg) begin
        pend_reg      <= 1'b1;
        snap_reg      <= snap_next_reg;
        tag_reg       <= tag_next_reg;
        pend_next_reg <= 1'b0;
      end
      if (any_change) begin
        case (state_reg)
          ST_SEND: begin
            if (!pend_next_reg) begin
              pend_next_reg <= 1'b1;
              snap_next_reg <= gpio_s_reg;
              tag_next_reg  <= global_counter + 8'd1;
              incr_reg      <= 1'b1;
            end else begin
              snap_next_reg <= gpio_s_reg;
              overrun_reg   <= 1'b1;
            end
          end
          ST_DONE: begin
            // The queued event is being promoted this cycle; merge into it.
            if (pend_next_reg) begin
              snap_reg    <= gpio_s_reg;
              overrun_reg <= 1'b1;
            end else begin
              pend_reg <= 1'b1;
              snap_reg <= gpio_s_reg;
              tag_reg  <= global_counter + 8'd1;
              incr_reg <= 1'b1;
            end
          end
          default: begin
            if (!pend_reg) begin
              pend_reg <= 1'b1;
              snap_reg <= gpio_s_reg;
              tag_reg  <= global_counter + 8'd1;
              incr_reg <= 1'b1;
            end else begin
              snap_reg    <= gpio_s_reg;
              overrun_reg <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (pend_reg) state_reg <= ST_REQ;
        ST_REQ: begin
          if (sl_arb_grant) begin
            state_reg <= ST_SEND;
            idx_reg   <= '0;
          end
        end
        ST_SEND: begin
          if (sl_arb_grant) begin
            if (last_byte) state_reg <= ST_DONE;
            else           idx_reg   <= idx_reg + IW'(1);
          end
        end
        default: state_reg <= pend_next_reg ? ST_REQ : ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_event_int.sv
// Directed and randomized checks of gpio_event_int against a frame-level model:
// each reported change yields EVT_CHAR, counter+1, then the pad levels MSB first.
module tb_gpio_event_int;
  localparam int         WIDTH    = 24;
  localparam logic [7:0] EVT_CHAR = 8'h67;
  localparam logic [7:0] GC_BASE  = 8'h10;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] gpio_in, gpio_direction;
  logic             evt_enable, sl_arb_grant;
  logic [7:0]       global_counter, sl_data;
  logic             incr_ctr, sl_arb_request, sl_data_latch, evt_overrun;

  int checks = 0, errors = 0;
  int incr_total = 0, req_cycles = 0, gap_strobes = 0, noreq_strobes = 0;
  int ev_count = 0;
  logic [7:0]       got_q [$];
  logic [WIDTH-1:0] pads;

  always #5 clk = ~clk;

  gpio_event_int #(.WIDTH(WIDTH), .EVT_CHAR(EVT_CHAR)) dut (
    .clk(clk), .reset(reset), .gpio_in(gpio_in), .gpio_direction(gpio_direction),
    .evt_enable(evt_enable), .global_counter(global_counter), .incr_ctr(incr_ctr),
    .sl_data(sl_data), .sl_arb_request(sl_arb_request), .sl_arb_grant(sl_arb_grant),
    .sl_data_latch(sl_data_latch), .evt_overrun(evt_overrun)
  );

  // Bus monitor: sampled mid-cycle, i.e. the values the DUT acts on at the next edge.
  always @(negedge clk) begin
    if (incr_ctr === 1'b1) incr_total++;
    if (sl_arb_request === 1'b1) req_cycles++;
    if (sl_data_latch === 1'b1) begin
      got_q.push_back(sl_data);
      if (sl_arb_grant !== 1'b1) gap_strobes++;
      if (sl_arb_request !== 1'b1) noreq_strobes++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    global_counter = GC_BASE + 8'(incr_total);
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] exp_frame(input logic [7:0] tag, input logic [23:0] lv);
    return {EVT_CHAR, tag, lv};
  endfunction

  function automatic logic [7:0] exp_tag();
    return GC_BASE + 8'(ev_count);
  endfunction

  task automatic wait_req(input string tag);
    int n = 0;
    while (sl_arb_request !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    check(tag, 64'(sl_arb_request), 64'd1);
  endtask

  // Grants the bus until five bytes arrive, optionally opening a grant gap and
  // toggling pads once a given number of bytes has been seen.
  task automatic collect(input string tag, input int gap_at, input int gap_len,
                         input logic [7:0] etag, input logic [23:0] elv,
                         input int tog_at, input logic [23:0] tog_mask);
    int base = got_q.size();
    int n = 0;
    bit gapped = 0, toggled = 0;
    logic [39:0] frame = '0;
    sl_arb_grant = 1'b1;
    while (got_q.size() - base < 5 && n < 200) begin
      cyc();
      n++;
      if (!toggled && tog_mask != '0 && got_q.size() - base == tog_at) begin
        pads    = pads ^ tog_mask;
        gpio_in = pads;
        toggled = 1;
      end
      if (!gapped && gap_len > 0 && got_q.size() - base == gap_at) begin
        sl_arb_grant = 1'b0;
        repeat (gap_len) cyc();
        sl_arb_grant = 1'b1;
        gapped = 1;
      end
    end
    check({tag, "_bytes"}, 64'(got_q.size() - base), 64'd5);
    for (int i = 0; i < 5; i++)
      frame = {frame[31:0], (base + i < got_q.size()) ? got_q[base + i] : 8'hxx};
    check(tag, 64'(frame), 64'(exp_frame(etag, elv)));
    check({tag, "_req_drop"}, 64'(sl_arb_request), 64'd0);
  endtask

  initial begin
    int i0, r0, s0, n;
    logic [7:0]  tag1;
    logic [23:0] lv1, mask;
    bit exp_ev;

    reset = 1'b0; pads = '0; gpio_in = '0; gpio_direction = '0;
    evt_enable = 1'b1; sl_arb_grant = 1'b0; global_counter = GC_BASE;
    repeat (3) cyc();
    check("rst_req", 64'(sl_arb_request), 64'd0);
    check("rst_latch", 64'(sl_data_latch), 64'd0);
    check("rst_data", 64'(sl_data), 64'd0);
    check("rst_incr", 64'(incr_ctr), 64'd0);
    check("rst_overrun", 64'(evt_overrun), 64'd0);
    reset = 1'b1;
    repeat (6) cyc();
    check("idle_req", 64'(sl_arb_request), 64'd0);

    // Latency and basic frame
    pads[0] = 1'b1; gpio_in = pads; ev_count++;
    cyc(); cyc();
    check("t1_incr_early", 64'(incr_ctr), 64'd0);
    cyc();
    check("t1_incr_at3", 64'(incr_ctr), 64'd1);
    check("t1_req_at3", 64'(sl_arb_request), 64'd0);
    cyc();
    check("t1_incr_once", 64'(incr_ctr), 64'd0);
    check("t1_req_at4", 64'(sl_arb_request), 64'd1);
    collect("t1_frame", 0, 0, exp_tag(), pads, 0, '0);
    check("t1_tag_literal", 64'(exp_tag()), 64'h11);
    sl_arb_grant = 1'b0;
    repeat (3) cyc();

    // Output-direction pin is ignored
    gpio_direction[5] = 1'b1; pads[5] = 1'b1; gpio_in = pads;
    i0 = incr_total; r0 = req_cycles;
    repeat (50) cyc();
    check("t2_no_incr", 64'(incr_total - i0), 64'd0);
    check("t2_no_req", 64'(req_cycles - r0), 64'd0);

    // Delayed grant then a two-cycle grant gap
    pads[2] = 1'b1; gpio_in = pads; ev_count++;
    wait_req("t3_req");
    s0 = got_q.size();
    repeat (10) cyc();
    check("t3_req_held", 64'(sl_arb_request), 64'd1);
    check("t3_no_bytes", 64'(got_q.size() - s0), 64'd0);
    collect("t3_frame", 2, 2, exp_tag(), pads, 0, '0);
    check("t3_gap_strobes", 64'(gap_strobes), 64'd0);
    sl_arb_grant = 1'b0;
    repeat (3) cyc();

    // Two changes before grant merge into one frame
    check("t4_overrun_before", 64'(evt_overrun), 64'd0);
    i0 = incr_total;
    pads[3] = 1'b1; gpio_in = pads; ev_count++;
    cyc(); cyc();
    pads[7] = 1'b1; gpio_in = pads;
    repeat (8) cyc();
    check("t4_one_incr", 64'(incr_total - i0), 64'd1);
    check("t4_overrun", 64'(evt_overrun), 64'd1);
    collect("t4_frame", 0, 0, exp_tag(), pads, 0, '0);
    sl_arb_grant = 1'b0;
    repeat (3) cyc();

    // Change during SEND is queued behind the current frame
    pads[6] = 1'b1; gpio_in = pads; ev_count++;
    tag1 = exp_tag(); lv1 = pads;
    wait_req("t5_req1");
    collect("t5_frame1", 0, 0, tag1, lv1, 1, 24'h000002);
    ev_count++;
    cyc();
    check("t5_req2", 64'(sl_arb_request), 64'd1);
    collect("t5_frame2", 0, 0, tag1 + 8'd1, pads, 0, '0);
    sl_arb_grant = 1'b0;
    repeat (3) cyc();

    // Reset in the middle of a frame
    pads[4] = 1'b1; gpio_in = pads; ev_count++;
    wait_req("t6_req");
    s0 = got_q.size(); n = 0;
    sl_arb_grant = 1'b1;
    while (got_q.size() - s0 < 2 && n < 50) begin
      cyc();
      n++;
    end
    reset = 1'b0;
    #1;
    check("t6_rst_req", 64'(sl_arb_request), 64'd0);
    check("t6_rst_latch", 64'(sl_data_latch), 64'd0);
    check("t6_rst_data", 64'(sl_data), 64'd0);
    check("t6_rst_incr", 64'(incr_ctr), 64'd0);
    check("t6_rst_overrun", 64'(evt_overrun), 64'd0);
    repeat (3) cyc();
    reset = 1'b1;
    r0 = req_cycles; i0 = incr_total; s0 = got_q.size();
    repeat (30) cyc();
    check("t6_post_req", 64'(req_cycles - r0), 64'd0);
    check("t6_post_incr", 64'(incr_total - i0), 64'd0);
    check("t6_post_bytes", 64'(got_q.size() - s0), 64'd0);
    sl_arb_grant = 1'b0;

    // Randomized: single/double pin toggles, random directions and enable
    for (int it = 0; it < 24; it++) begin
      gpio_direction = 24'($urandom) & 24'($urandom);
      evt_enable = ($urandom_range(0, 4) != 0);
      mask = 24'(1) << $urandom_range(0, 23);
      if ($urandom_range(0, 1) == 1) mask = mask | (24'(1) << $urandom_range(0, 23));
      exp_ev = evt_enable && ((mask & ~gpio_direction) != '0);
      i0 = incr_total;
      pads = pads ^ mask; gpio_in = pads;
      repeat (6) cyc();
      check("rnd_incr", 64'(incr_total - i0), 64'(exp_ev));
      if (exp_ev) begin
        ev_count++;
        collect("rnd_frame", $urandom_range(1, 4), $urandom_range(0, 3), exp_tag(), pads, 0, '0);
        sl_arb_grant = 1'b0;
      end else begin
        check("rnd_noreq", 64'(sl_arb_request), 64'd0);
      end
      evt_enable = 1'b1;
      repeat (3) cyc();
    end
    check("noreq_strobes", 64'(noreq_strobes), 64'd0);
    check("gap_strobes_final", 64'(gap_strobes), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
